stream_rr_mux: RTL and testbench

//  N-channel float-sample stream concentrator for the filter test environment. Each input channel has a

---
 rtl/stream_rr_mux.sv | 157 +++++++++++++++
 tb/tb_stream_rr_mux.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_mux.sv
// stream_rr_mux: N-channel stream concentrator.
// Each input channel feeds its own small FIFO. A round-robin arbiter moves one
// sample per cycle from the FIFOs into a registered output stage. Each output
// sample is tagged with its source channel. All ports use the stb/ack handshake.
module stream_rr_mux #(
  parameter int DATA_W     = 32,
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   input_a,
  input  logic [N_CH-1:0]          input_a_stb,
  output logic [N_CH-1:0]          input_a_ack,
  input  logic [N_CH-1:0]          ch_enable,
  output logic [DATA_W-1:0]        output_z,
  output logic [CH_W-1:0]          output_z_ch,
  output logic                     output_z_stb,
  input  logic                     output_z_ack,
  output logic [N_CH*(AW+1)-1:0]   ch_count,
  output logic [31:0]              out_count
);

  // Per-channel status and data offered to the arbiter
  logic [N_CH-1:0]              full;
  logic [N_CH-1:0]              eligible;
  logic [N_CH-1:0]              pop;
  logic [N_CH-1:0][DATA_W-1:0]  head_data;

  // Output stage registers
  logic [DATA_W-1:0] output_z_q,     output_z_d;
  logic [CH_W-1:0]   output_z_ch_q,  output_z_ch_d;
  logic              output_z_stb_q, output_z_stb_d;
  logic [CH_W-1:0]   ptr_q,          ptr_d;
  logic [31:0]       out_count_q;

  // Arbiter results
  logic              out_free;
  logic              arb_found;
  logic              arb_load;
  logic [CH_W-1:0]   arb_sel;
  logic [CH_W-1:0]   arb_cand;

  // The output stage can take a new sample when it is empty or being drained now.
  assign out_free = ~output_z_stb_q | output_z_ack;
  assign arb_load = out_free & arb_found;

  // ---------------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              push;

    // Ready depends only on registered occupancy, so there is no
    // combinational path from any stb or from output_z_ack.
    assign full[gi]        = (count_q == (AW+1)'(FIFO_DEPTH));
    assign input_a_ack[gi] = ~full[gi] & ~rst;
    assign push            = input_a_stb[gi] & input_a_ack[gi];
    assign pop[gi]         = arb_load & (arb_sel == CH_W'(gi));
    assign eligible[gi]    = (count_q != '0) & ch_enable[gi];
    assign head_data[gi]   = mem_q[rd_ptr_q];
    assign ch_count[gi*(AW+1) +: AW+1] = count_q;

    // Pointer and occupancy tracking; reset empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push)
          wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop[gi])
          rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop[gi])
          count_q <= count_q + 1'b1;
        else if (!push && pop[gi])
          count_q <= count_q - 1'b1;
      end
    end

    // Sample storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
      if (push)
        mem_q[wr_ptr_q] <= input_a[gi*DATA_W +: DATA_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search starting just after the last granted channel
  // ---------------------------------------------------------------------------
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_cand  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      arb_cand = CH_W'((int'(ptr_q) + i) % N_CH);
      if (!arb_found && eligible[arb_cand]) begin
        arb_found = 1'b1;
        arb_sel   = arb_cand;
      end
    end
  end

  // Next state of the output stage: load on grant, go idle when nothing is eligible
  always_comb begin
    output_z_d     = output_z_q;
    output_z_ch_d  = output_z_ch_q;
    output_z_stb_d = output_z_stb_q;
    ptr_d          = ptr_q;
    if (out_free) begin
      if (arb_found) begin
        output_z_d     = head_data[arb_sel];
        output_z_ch_d  = arb_sel;
        output_z_stb_d = 1'b1;
        ptr_d          = arb_sel;
      end else begin
        output_z_stb_d = 1'b0;
      end
    end
  end

  // Output stage registers; pointer resets to the last channel so channel 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_z_q     <= '0;
      output_z_ch_q  <= '0;
      output_z_stb_q <= 1'b0;
      ptr_q          <= CH_W'(N_CH - 1);
    end else begin
      output_z_q     <= output_z_d;
      output_z_ch_q  <= output_z_ch_d;
      output_z_stb_q <= output_z_stb_d;
      ptr_q          <= ptr_d;
    end
  end

  // Completed output transfers, wrapping naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_count_q <= '0;
    else if (output_z_stb_q && output_z_ack)
      out_count_q <= out_count_q + 32'd1;
  end

  assign output_z     = output_z_q;
  assign output_z_ch  = output_z_ch_q;
  assign output_z_stb = output_z_stb_q;
  assign out_count    = out_count_q;

endmodule

// File: tb/tb_stream_rr_mux.sv
// Directed testbench for stream_rr_mux (4 channels, 32-bit samples, depth 4).
module tb_stream_rr_mux;

  localparam int DATA_W = 32;
  localparam int N_CH   = 4;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 2;
  localparam int AW     = 2;

  logic                    clk;
  logic                    rst;
  logic [N_CH*DATA_W-1:0]  input_a;
  logic [N_CH-1:0]         input_a_stb;
  logic [N_CH-1:0]         input_a_ack;
  logic [N_CH-1:0]         ch_enable;
  logic [DATA_W-1:0]       output_z;
  logic [CH_W-1:0]         output_z_ch;
  logic                    output_z_stb;
  logic                    output_z_ack;
  logic [N_CH*(AW+1)-1:0]  ch_count;
  logic [31:0]             out_count;

  int checks = 0;
  int errors = 0;

  stream_rr_mux #(
    .DATA_W(DATA_W), .N_CH(N_CH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .ch_enable(ch_enable),
    .output_z(output_z), .output_z_ch(output_z_ch),
    .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
    .ch_count(ch_count), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW:0] cnt(input int k);
    return ch_count[k*(AW+1) +: AW+1];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    input_a = {4{32'hDEADBEEF}};
    input_a_stb = 4'hF;
    ch_enable = 4'hF;
    output_z_ack = 1'b0;
    repeat (3) step();
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", output_z_stb); end
    checks++; if (input_a_ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", input_a_ack); end
    checks++; if (ch_count !== '0) begin errors++; $display("FAIL reset_ch_count: got %h expected 0", ch_count); end
    checks++; if (out_count !== 32'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
    checks++; if (output_z !== 32'd0) begin errors++; $display("FAIL reset_output_z: got %h expected 0", output_z); end
    rst = 1'b0;
    input_a_stb = 4'h0;
    step();
    checks++; if (input_a_ack !== 4'hF) begin errors++; $display("FAIL release_ack: got %b expected 1111", input_a_ack); end
    $display("test_reset done");
  endtask

  task automatic test_all_channels();
    output_z_ack = 1'b1;
    for (int k = 0; k < N_CH; k++) input_a[k*DATA_W +: DATA_W] = 32'h3F800000 + k;
    input_a_stb = 4'hF;
    step();
    input_a_stb = 4'h0;
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL no_bypass: got stb %b expected 0", output_z_stb); end
    checks++; if (ch_count !== 12'b001_001_001_001) begin errors++; $display("FAIL push_counts: got %b expected 001001001001", ch_count); end
    for (int k = 0; k < N_CH; k++) begin
      step();
      checks++;
      if (output_z_stb !== 1'b1 || output_z_ch !== CH_W'(k) || output_z !== 32'h3F800000 + k) begin
        errors++;
        $display("FAIL all_ch_out%0d: got stb=%b ch=%0d z=%h expected stb=1 ch=%0d z=%h",
                 k, output_z_stb, output_z_ch, output_z, k, 32'h3F800000 + k);
      end
      $display("all_channels: out ch=%0d z=%h", output_z_ch, output_z);
    end
    step();
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL all_ch_idle: got stb %b expected 0", output_z_stb); end
    checks++; if (out_count !== 32'd4) begin errors++; $display("FAIL all_ch_count: got %0d expected 4", out_count); end
  endtask

  task automatic test_backpressure();
    int got;
    logic clr;
    output_z_ack = 1'b0;
    input_a_stb = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      input_a[1*DATA_W +: DATA_W] = 32'h40000000 + i;
      step();
    end
    input_a[1*DATA_W +: DATA_W] = 32'h40000005;
    checks++; if (input_a_ack[1] !== 1'b0) begin errors++; $display("FAIL bp_full_ack: got %b expected 0", input_a_ack[1]); end
    checks++; if (cnt(1) !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", cnt(1)); end
    step();
    checks++;
    if (output_z_stb !== 1'b1 || output_z !== 32'h40000000 || output_z_ch !== 2'd1) begin
      errors++;
      $display("FAIL bp_hold: got stb=%b ch=%0d z=%h expected stb=1 ch=1 z=40000000", output_z_stb, output_z_ch, output_z);
    end
    output_z_ack = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (output_z_stb) begin
        checks++;
        if (output_z !== 32'h40000000 + got || output_z_ch !== 2'd1) begin
          errors++;
          $display("FAIL bp_order%0d: got ch=%0d z=%h expected ch=1 z=%h", got, output_z_ch, output_z, 32'h40000000 + got);
        end
        $display("backpressure: out ch=%0d z=%h", output_z_ch, output_z);
        got++;
      end
      clr = input_a_stb[1] & input_a_ack[1];
      step();
      if (clr) input_a_stb = 4'h0;
    end
    checks++; if (got !== 6) begin errors++; $display("FAIL bp_total: got %0d outputs expected 6", got); end
    checks++; if (out_count !== 32'd10) begin errors++; $display("FAIL bp_out_count: got %0d expected 10", out_count); end
  endtask

  task automatic test_fairness();
    int prev;
    int n;
    logic [31:0] v0;
    logic [31:0] v2;
    logic p0;
    logic p2;
    prev = -1;
    n = 0;
    v0 = 32'h10000000;
    v2 = 32'h30000000;
    output_z_ack = 1'b1;
    input_a_stb = 4'b0101;
    for (int c = 0; c < 24; c++) begin
      input_a[0*DATA_W +: DATA_W] = v0;
      input_a[2*DATA_W +: DATA_W] = v2;
      if (output_z_stb) begin
        checks++;
        if (!(output_z_ch == 2'd0 || output_z_ch == 2'd2) || int'(output_z_ch) == prev) begin
          errors++;
          $display("FAIL fair_ch: got ch=%0d after ch=%0d expected alternating 0/2", output_z_ch, prev);
        end
        $display("fairness: out ch=%0d z=%h", output_z_ch, output_z);
        prev = int'(output_z_ch);
        n++;
      end
      p0 = input_a_ack[0];
      p2 = input_a_ack[2];
      step();
      if (p0) v0 = v0 + 1;
      if (p2) v2 = v2 + 1;
    end
    input_a_stb = 4'h0;
    repeat (12) step();
    checks++; if (n < 16) begin errors++; $display("FAIL fair_rate: got %0d outputs expected >=16", n); end
    checks++; if (output_z_stb !== 1'b0 || ch_count !== '0) begin errors++; $display("FAIL fair_drain: got stb=%b counts=%h expected 0", output_z_stb, ch_count); end
  endtask

  task automatic test_mask();
    int got;
    ch_enable = 4'b0111;
    output_z_ack = 1'b1;
    input_a_stb = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      input_a[3*DATA_W +: DATA_W] = 32'h50000000 + i;
      step();
      checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL mask_no_out%0d: got stb %b expected 0", i, output_z_stb); end
    end
    input_a_stb = 4'h0;
    repeat (2) step();
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL mask_idle: got stb %b expected 0", output_z_stb); end
    checks++; if (cnt(3) !== 3'd4) begin errors++; $display("FAIL mask_count: got %0d expected 4", cnt(3)); end
    checks++; if (input_a_ack[3] !== 1'b0) begin errors++; $display("FAIL mask_ack: got %b expected 0", input_a_ack[3]); end
    ch_enable = 4'hF;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (output_z_stb) begin
        checks++;
        if (output_z_ch !== 2'd3 || output_z !== 32'h50000000 + got) begin
          errors++;
          $display("FAIL mask_drain%0d: got ch=%0d z=%h expected ch=3 z=%h", got, output_z_ch, output_z, 32'h50000000 + got);
        end
        $display("mask: out ch=%0d z=%h", output_z_ch, output_z);
        got++;
      end
      step();
    end
    checks++; if (got !== 4) begin errors++; $display("FAIL mask_total: got %0d expected 4", got); end
  endtask

  task automatic test_midstream_reset();
    output_z_ack = 1'b0;
    input_a[0*DATA_W +: DATA_W] = 32'h60000000;
    input_a[1*DATA_W +: DATA_W] = 32'h61000000;
    input_a_stb = 4'b0011;
    repeat (3) step();
    input_a_stb = 4'h0;
    checks++; if (output_z_stb !== 1'b1) begin errors++; $display("FAIL mid_pre_stb: got %b expected 1", output_z_stb); end
    rst = 1'b1;
    #1;
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL mid_rst_stb: got %b expected 0", output_z_stb); end
    checks++; if (ch_count !== '0) begin errors++; $display("FAIL mid_rst_counts: got %h expected 0", ch_count); end
    checks++; if (input_a_ack !== 4'h0) begin errors++; $display("FAIL mid_rst_ack: got %b expected 0000", input_a_ack); end
    checks++; if (output_z !== 32'd0 || out_count !== 32'd0) begin errors++; $display("FAIL mid_rst_regs: got z=%h cnt=%0d expected 0", output_z, out_count); end
    repeat (2) step();
    rst = 1'b0;
    output_z_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: got stb %b expected 0", c, output_z_stb); end
    end
    checks++; if (input_a_ack !== 4'hF) begin errors++; $display("FAIL mid_ack: got %b expected 1111", input_a_ack); end
    $display("midstream_reset done");

    force dut.out_count_q = 32'hFFFFFFFF;
    #1;
    release dut.out_count_q;
    checks++; if (out_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffffffff", out_count); end
    input_a[0*DATA_W +: DATA_W] = 32'h00000077;
    input_a_stb = 4'b0001;
    step();
    input_a_stb = 4'h0;
    step();
    checks++;
    if (output_z_stb !== 1'b1 || output_z !== 32'h00000077 || output_z_ch !== 2'd0) begin
      errors++;
      $display("FAIL wrap_out: got stb=%b ch=%0d z=%h expected stb=1 ch=0 z=00000077", output_z_stb, output_z_ch, output_z);
    end
    step();
    checks++; if (out_count !== 32'd0) begin errors++; $display("FAIL wrap_count: got %h expected 0", out_count); end
    $display("wrap: out_count=%h", out_count);
  endtask

  initial begin
    rst = 1'b1;
    input_a = '0;
    input_a_stb = '0;
    ch_enable = '1;
    output_z_ack = 1'b0;
    test_reset();
    test_all_channels();
    test_backpressure();
    test_fairness();
    test_mask();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
